sd_dat_rx: RTL and testbench

SD_DAT_RX -- requirements
Module: sd_dat_rx

---
 rtl/sd_dat_rx.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_sd_dat_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dat_rx.sv
// sd_dat_rx: SD 4-bit DAT-line block receiver.
// Data nibbles are sampled on sd_clk_rise, packed into 32-bit words and
// buffered in a FIFO that is read through an Avalon-MM register interface.
// Optional feature macro: SD_DAT_RX_CRC_EN enables per-line CRC16 checking.
//
// state          | meaning
// S_IDLE         | waiting for a start command
// S_WAIT_START   | waiting for the all-zero start nibble, timeout running
// S_DATA         | receiving data nibbles, high nibble of each byte first
// S_CRC          | 16 CRC bits per line, MSB first
// S_END_BIT      | end bit, all lines must be high
module sd_dat_rx #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sd_clk_rise,
  input  logic [3:0]  sd_dat_in,
  output logic        sd_clk_hold,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_START = 3'd1;
  localparam logic [2:0] S_DATA       = 3'd2;
  localparam logic [2:0] S_CRC        = 3'd3;
  localparam logic [2:0] S_END_BIT    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [15:0]      tick_cnt_q, tick_cnt_d;
  logic [2:0]       nib_cnt_q, nib_cnt_d;
  logic [27:0]      shift_q, shift_d;
  logic [9:0]       word_cnt_q, word_cnt_d;
  logic [3:0]       crc_cnt_q, crc_cnt_d;
  logic             done_q, done_d;
  logic             crc_err_q, crc_err_d;
  logic             end_err_q, end_err_d;
  logic             tmo_flag_q, tmo_flag_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      tmo_reg_q, tmo_reg_d;
  logic [11:0]      blk_len_q, blk_len_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [31:0]      mem_q [FIFO_DEPTH];

  logic             wr_en;
  logic             rd_en;
  logic             start;
  logic             abort;
  logic             pop;
  logic             push;
  logic             push_ok;
  logic             fifo_full;
  logic             fifo_empty;
  logic             crc_mismatch;
  logic [9:0]       words_last;
  logic [31:0]      push_word;
  logic [31:0]      status_w;
  logic             unused_wdata;

  assign wr_en      = chipselect & ~write_n;
  assign rd_en      = chipselect & ~read_n;
  assign start      = wr_en & (address == 2'd1) & writedata[0];
  assign abort      = wr_en & (address == 2'd1) & writedata[1];
  assign fifo_full  = (level_q == LVL_FULL);
  assign fifo_empty = (level_q == '0);
  assign pop        = rd_en & (address == 2'd0) & ~fifo_empty;
  assign push_ok    = push & ~fifo_full & ~abort;
  assign push_word  = {shift_q, sd_dat_in};

  // A block shorter than one word still transfers one word.
  assign words_last = (blk_len_q[11:2] == 10'd0) ? 10'd0 : (blk_len_q[11:2] - 10'd1);

  assign sd_clk_hold  = (state_q == S_DATA) & fifo_full;
  assign irq          = done_q | crc_err_q | end_err_q | tmo_flag_q | overrun_q;
  assign readdata     = readdata_q;
  assign unused_wdata = ^writedata[31:16];

`ifdef SD_DAT_RX_CRC_EN
  logic [15:0] crc_q [4];
  logic [15:0] crc_d [4];

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Per-line CRC: cleared on the start nibble, fed by data bits, then shifted
  // out MSB first and compared against the received CRC bits.
  always_comb begin
    crc_mismatch = 1'b0;
    for (int l = 0; l < 4; l++) begin
      crc_d[l] = crc_q[l];
      if (sd_clk_rise) begin
        if (state_q == S_WAIT_START && sd_dat_in == 4'h0) begin
          crc_d[l] = 16'h0000;
        end else if (state_q == S_DATA) begin
          crc_d[l] = crc16_step(crc_q[l], sd_dat_in[l]);
        end else if (state_q == S_CRC) begin
          crc_d[l] = {crc_q[l][14:0], 1'b0};
          if (sd_dat_in[l] != crc_q[l][15]) crc_mismatch = 1'b1;
        end
      end
    end
  end

  // CRC line registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int l = 0; l < 4; l++) crc_q[l] <= 16'h0000;
    end else begin
      for (int l = 0; l < 4; l++) crc_q[l] <= crc_d[l];
    end
  end
`else
  // CRC bits are clocked through by the FSM but never checked.
  assign crc_mismatch = 1'b0;
`endif

  // Receive sequencing; start/abort act on the next clk, everything else on SD ticks.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    nib_cnt_d  = nib_cnt_q;
    shift_d    = shift_q;
    word_cnt_d = word_cnt_q;
    crc_cnt_d  = crc_cnt_q;
    done_d     = done_q;
    crc_err_d  = crc_err_q;
    end_err_d  = end_err_q;
    tmo_flag_d = tmo_flag_q;
    overrun_d  = overrun_q;
    push       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          done_d     = 1'b0;
          crc_err_d  = 1'b0;
          end_err_d  = 1'b0;
          tmo_flag_d = 1'b0;
          overrun_d  = 1'b0;
          tick_cnt_d = 16'd0;
          state_d    = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (sd_clk_rise) begin
          if (sd_dat_in == 4'h0) begin
            nib_cnt_d  = 3'd0;
            word_cnt_d = 10'd0;
            state_d    = S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 16'd1;
            if (tmo_reg_q != 16'd0 && (tick_cnt_q + 16'd1) == tmo_reg_q) begin
              tmo_flag_d = 1'b1;
              state_d    = S_IDLE;
            end
          end
        end
      end
      S_DATA: begin
        if (sd_clk_rise) begin
          shift_d   = {shift_q[23:0], sd_dat_in};
          nib_cnt_d = nib_cnt_q + 3'd1;
          if (nib_cnt_q == 3'd7) begin
            push = 1'b1;
            if (fifo_full) overrun_d = 1'b1;
            word_cnt_d = word_cnt_q + 10'd1;
            if (word_cnt_q == words_last) begin
              crc_cnt_d = 4'd0;
              state_d   = S_CRC;
            end
          end
        end
      end
      S_CRC: begin
        if (sd_clk_rise) begin
          if (crc_mismatch) crc_err_d = 1'b1;
          crc_cnt_d = crc_cnt_q + 4'd1;
          if (crc_cnt_q == 4'd15) state_d = S_END_BIT;
        end
      end
      S_END_BIT: begin
        if (sd_clk_rise) begin
          if (sd_dat_in != 4'hF) end_err_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d   = S_IDLE;
      nib_cnt_d = 3'd0;
      shift_d   = 28'd0;
    end
  end

  // FIFO pointers and fill level; abort flushes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Register writes and registered read data.
  always_comb begin
    tmo_reg_d  = tmo_reg_q;
    blk_len_d  = blk_len_q;
    readdata_d = readdata_q;

    status_w            = 32'd0;
    status_w[0]         = (state_q != S_IDLE);
    status_w[1]         = done_q;
    status_w[2]         = crc_err_q;
    status_w[3]         = end_err_q;
    status_w[4]         = tmo_flag_q;
    status_w[5]         = overrun_q;
    status_w[6 +: LVL_W] = level_q;

    if (wr_en && address == 2'd2) tmo_reg_d = writedata[15:0];
    if (wr_en && address == 2'd3) blk_len_d = writedata[11:0];

    if (rd_en) begin
      case (address)
        2'd0:    readdata_d = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];
        2'd1:    readdata_d = status_w;
        2'd2:    readdata_d = {16'd0, tmo_reg_q};
        default: readdata_d = {20'd0, blk_len_q};
      endcase
    end
  end

  // State, counters, flags and registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= 16'd0;
      nib_cnt_q  <= 3'd0;
      shift_q    <= 28'd0;
      word_cnt_q <= 10'd0;
      crc_cnt_q  <= 4'd0;
      done_q     <= 1'b0;
      crc_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
      tmo_flag_q <= 1'b0;
      overrun_q  <= 1'b0;
      tmo_reg_q  <= 16'hFFFF;
      blk_len_q  <= 12'd512;
      readdata_q <= 32'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      nib_cnt_q  <= nib_cnt_d;
      shift_q    <= shift_d;
      word_cnt_q <= word_cnt_d;
      crc_cnt_q  <= crc_cnt_d;
      done_q     <= done_d;
      crc_err_q  <= crc_err_d;
      end_err_q  <= end_err_d;
      tmo_flag_q <= tmo_flag_d;
      overrun_q  <= overrun_d;
      tmo_reg_q  <= tmo_reg_d;
      blk_len_q  <= blk_len_d;
      readdata_q <= readdata_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

endmodule

// File: tb/tb_sd_dat_rx.sv
// tb_sd_dat_rx: scoreboard bench for sd_dat_rx (default FIFO_DEPTH 16).
module tb_sd_dat_rx;

  localparam int LVL_W = 5;
`ifdef SD_DAT_RX_CRC_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sd_clk_rise = 1'b0;
  logic [3:0]  sd_dat_in = 4'hF;
  logic        sd_clk_hold;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        irq;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;

  sd_dat_rx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sd_clk_rise (sd_clk_rise),
    .sd_dat_in   (sd_dat_in),
    .sd_clk_hold (sd_clk_hold),
    .address     (address),
    .chipselect  (chipselect),
    .read_n      (read_n),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic busy, input logic done, input logic crc,
                                     input logic endb, input logic tmo, input logic ovr,
                                     input logic [LVL_W-1:0] lvl);
    logic [31:0] s;
    s = 32'd0;
    s[0] = busy; s[1] = done; s[2] = crc; s[3] = endb; s[4] = tmo; s[5] = ovr;
    s[6 +: LVL_W] = lvl;
    return s;
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic [15:0] n;
    n = {c[14:0], 1'b0};
    if (c[15] ^ b) n = n ^ 16'h1021;
    return n;
  endfunction

  task automatic avm_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic avm_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  task automatic tick(input logic [3:0] n);
    @(negedge clk);
    sd_dat_in = n; sd_clk_rise = 1'b1;
    @(negedge clk);
    sd_clk_rise = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 8; k++) tick(w[31 - 4*k -: 4]);
  endtask

  task automatic check_status(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    avm_read(2'd1, d);
    chk(tag, d, exp);
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    avm_read(2'd0, d);
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(tag, d, e);
    end
  endtask

  // Start nibble, n bytes base, base+1, ..., CRC per line, end nibble.
  // flip_line/flip_idx corrupt one transmitted CRC bit (time index, MSB first).
  task automatic send_block(input logic [7:0] base, input int n, input logic [3:0] end_nib,
                            input int flip_line, input int flip_idx);
    logic [15:0] crc [4];
    logic [7:0]  bt;
    logic [3:0]  nib;
    logic [31:0] w;
    for (int l = 0; l < 4; l++) crc[l] = 16'h0000;
    w = 32'd0;
    tick(4'h0);
    for (int j = 0; j < n; j++) begin
      bt = base + 8'(j);
      for (int h = 0; h < 2; h++) begin
        nib = (h == 0) ? bt[7:4] : bt[3:0];
        tick(nib);
        for (int l = 0; l < 4; l++) crc[l] = crc_step(crc[l], nib[l]);
      end
      w = {w[23:0], bt};
      if (j % 4 == 3) exp_q.push_back(w);
    end
    for (int i = 0; i < 16; i++) begin
      for (int l = 0; l < 4; l++) begin
        nib[l] = crc[l][15 - i];
        if (l == flip_line && i == flip_idx) nib[l] = ~nib[l];
      end
      tick(nib);
    end
    tick(end_nib);
  endtask

  initial begin
    logic [31:0] w;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_hold", 32'(sd_clk_hold), 32'd0);
    reset_n = 1'b1;
    check_status("rst_status", st(0, 0, 0, 0, 0, 0, 0));
    avm_read(2'd2, rd); chk("rst_timeout_reg", rd, 32'h0000FFFF);
    avm_read(2'd3, rd); chk("rst_blklen_reg", rd, 32'd512);

    // Length 8, bytes 01..08, good CRC
    avm_write(2'd3, 32'd8);
    avm_write(2'd1, 32'd1);
    check_status("t1_busy", st(1, 0, 0, 0, 0, 0, 0));
    send_block(8'h01, 8, 4'hF, -1, -1);
    check_status("t1_status", st(0, 1, 0, 0, 0, 0, 2));
    chk("t1_irq", 32'(irq), 32'd1);
    pop_check("t1_word0");
    pop_check("t1_word1");
    avm_read(2'd0, rd); chk("t1_empty_read", rd, 32'd0);
    check_status("t1_empty_level", st(0, 1, 0, 0, 0, 0, 0));

    // Same block, DAT2 CRC bit 7 flipped
    avm_write(2'd1, 32'd1);
    send_block(8'h01, 8, 4'hF, 2, 8);
    check_status("t2_crc_status", st(0, 1, CRC_ON, 0, 0, 0, 2));
    pop_check("t2_word0");
    pop_check("t2_word1");

    // Timeout 5 with lines idle high
    avm_write(2'd2, 32'd5);
    avm_read(2'd2, rd); chk("t3_timeout_reg", rd, 32'd5);
    avm_write(2'd1, 32'd1);
    repeat (4) tick(4'hF);
    check_status("t3_before", st(1, 0, 0, 0, 0, 0, 0));
    tick(4'hF);
    check_status("t3_timeout", st(0, 0, 0, 0, 1, 0, 0));
    chk("t3_irq", 32'(irq), 32'd1);

    // Length 512: fill, hold, overrun, drain, abort
    avm_write(2'd2, 32'd0);
    avm_write(2'd3, 32'd512);
    avm_write(2'd1, 32'd1);
    tick(4'h0);
    for (int k = 0; k < 15; k++) begin
      w = $urandom;
      exp_q.push_back(w);
      send_word(w);
    end
    chk("t4_hold_15", 32'(sd_clk_hold), 32'd0);
    w = $urandom;
    exp_q.push_back(w);
    send_word(w);
    chk("t4_hold_16", 32'(sd_clk_hold), 32'd1);
    check_status("t4_full", st(1, 0, 0, 0, 0, 0, 16));
    send_word($urandom);
    check_status("t4_overrun", st(1, 0, 0, 0, 0, 1, 16));
    chk("t4_hold_ovr", 32'(sd_clk_hold), 32'd1);
    pop_check("t4_pop0");
    chk("t4_hold_released", 32'(sd_clk_hold), 32'd0);
    for (int k = 1; k < 16; k++) pop_check($sformatf("t4_pop%0d", k));
    send_word($urandom);
    check_status("t4_one_word", st(1, 0, 0, 0, 0, 1, 1));
    avm_write(2'd1, 32'd2);
    check_status("t4_abort", st(0, 0, 0, 0, 0, 1, 0));
    avm_read(2'd0, rd); chk("t4_flushed_read", rd, 32'd0);
    check_status("t4_empty_read_level", st(0, 0, 0, 0, 0, 1, 0));

    // Reset mid-block, then minimum-length block
    avm_write(2'd1, 32'd1);
    tick(4'h0);
    for (int k = 0; k < 12; k++) tick(4'(k + 3));
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_rst_readdata", readdata, 32'd0);
    chk("t5_rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    check_status("t5_rst_status", st(0, 0, 0, 0, 0, 0, 0));
    avm_read(2'd3, rd); chk("t5_rst_blklen", rd, 32'd512);
    avm_read(2'd2, rd); chk("t5_rst_timeout", rd, 32'h0000FFFF);
    avm_write(2'd3, 32'd2);
    avm_write(2'd1, 32'd1);
    send_block(8'hC0, 4, 4'hF, -1, -1);
    check_status("t5_min_len", st(0, 1, 0, 0, 0, 0, 1));
    pop_check("t5_word");

    // Bad end bit
    avm_write(2'd3, 32'd4);
    avm_write(2'd1, 32'd1);
    send_block(8'h55, 4, 4'hE, -1, -1);
    check_status("t6_end_err", st(0, 1, 0, 1, 0, 0, 1));
    pop_check("t6_word");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
